reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
Parametrised multi-port register file, the successor to the single-write / two-read RegFile.
- Read-port count is parametric (NR); two write ports.
- Write-to-read bypass: same-cycle writes are visible on the read ports.
- Hardware clear sweep after reset, with a Ready flag.
- Sits in the SPORK datapath between decode and ALU; the issue logic holds off until Ready=1.

Parameters:
W, 8, data path width in bits
D, 4, address width; depth = 2**D entries
NR, 2, number of read ports (1..8)

Ports:
CLK  input  1  clock; all state updates on rising edge
Reset_n  input  1  synchronous, active-low reset
RegWrite0  input  1  write enable, write port 0
writeReg0  input  D  write address, port 0
writeValue0  input  W  write data, port 0
RegWrite1  input  1  write enable, write port 1
writeReg1  input  D  write address, port 1
writeValue1  input  W  write data, port 1
srcIdx  input  NR*D  packed read addresses; port k at bits [k*D +: D]
ReadData  output  NR*W  packed read data; port k at bits [k*W +: W]
Ready  output  1  1 = clear sweep done, file accepts writes

Behaviour:
- Reset: one clock and one reset, as already decided; reset is synchronous and active-low.
  - Reset_n=0 sampled at a CLK edge: FSM -> CLEAR, sweep pointer=0, Ready=0. Storage is not cleared in that cycle.
  - Reset asserted mid-sweep or in RUN: the sweep restarts from entry 0. Held reset keeps pointer=0.
- FSM states: CLEAR, RUN.
  - CLEAR, each edge with Reset_n=1: entry[ptr] <= 0, ptr <= ptr+1.
  - When ptr = 2**D-1 is written: -> RUN, Ready=1 on the next cycle.
  - Sweep length = 2**D cycles after reset release (16 for D=4).
  - RUN is held until the next reset.
- Ready:
  - Registered output; 0 from the first reset edge through the end of the sweep.
  - Ready=1 exactly 2**D edges after the first edge with Reset_n=1.
- Writes:
  - Accepted only in RUN. RegWriteX=1 writes writeValueX to entry[writeRegX] at the rising edge.
  - In CLEAR both write enables are ignored, and the write data is dropped.
  - Both ports enabled, same address: port 1 wins; port 0's write is dropped.
  - Both ports enabled, different addresses: both commit the same edge.
- Reads:
  - Combinational, zero latency, for each read port k.
  - While Ready=0: ReadData[k]=0 regardless of address.
  - In RUN, bypass priority:
    - RegWrite1 && writeReg1==srcIdx[k]: writeValue1.
    - Else RegWrite0 && writeReg0==srcIdx[k]: writeValue0.
    - Else entry[srcIdx[k]].
  - Bypass applies in the same cycle the write is presented, before the edge.
  - Multiple read ports may read the same address; all return identical data.
- Widths: addresses are unsigned D bits and always in range; no out-of-range case. Data is stored unmodified.
- No X propagation: storage is defined after the sweep, and reads are forced to 0 before it.

Optional Feature:
ZERO_REG_EN
- Defined: entry 0 is hardwired zero. Reads of address 0 return 0, with no bypass. Writes to address 0 are discarded on both ports.
- Conflict rule in this case: port 1 writing address 0 does not block port 0 writing a different address.
- Not defined: entry 0 is an ordinary register.

Test Plan:
1. Reset_n=0 for 2 edges, then release -> Ready=0 and all ReadData=0 for 16 edges. Ready=1 on edge 16. Read every address -> 0x00.
2. RUN: RegWrite0=1, writeReg0=1, writeValue0=0x67 with srcIdx port0=1 -> ReadData port0=0x67 in the same cycle (bypass). After the edge with RegWrite0=0 -> still 0x67.
3. Both ports write address 2: port0=0xAB, port1=0xFE -> bypass shows 0xFE; stored value is 0xFE. Different addresses 3/4 with 0x11/0x22 -> both stored.
4. During CLEAR, RegWrite0=1, writeReg0=5, writeValue0=0x5A -> ignored. After Ready=1, address 5 reads 0x00.
5. Write 0x33 to address 7, then assert Reset_n=0 for 1 edge mid-RUN (also a second time at sweep cycle 8) -> Ready drops. A full 16-cycle sweep runs from entry 0; address 7 reads 0x00.
6. ZERO_REG_EN defined: write 0x99 to address 0 via port 1 while port 0 writes 0x44 to address 3 -> address 0 reads 0x00, address 3 reads 0x44. Undefined: address 0 reads 0x99.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file with NR combinational read ports and two write
// ports. After reset a hardware sweep zeroes every entry, one per clock, and then raises
// Ready. Reads see same-cycle writes through a bypass, and port 1 has priority over port 0.
//
// Optional feature macro: ZERO_REG_EN. When it is defined, entry 0 is hardwired to zero:
// reads of address 0 return 0 with no bypass, and writes to address 0 are discarded.
//
// Parameters:
//   W  - data width in bits
//   D  - address width; depth = 2**D entries
//   NR - number of read ports (1..8)
//
// Ports:
//   CLK         - clock; all state changes on the rising edge
//   Reset_n     - synchronous active-low reset
//   RegWrite0   - write enable, port 0
//   writeReg0   - write address, port 0
//   writeValue0 - write data, port 0
//   RegWrite1   - write enable, port 1 (wins on an address collision)
//   writeReg1   - write address, port 1
//   writeValue1 - write data, port 1
//   srcIdx      - packed read addresses; port k at [k*D +: D]
//   ReadData    - packed read data; port k at [k*W +: W]
//   Ready       - 1 once the clear sweep has finished and writes are accepted
module reg_file_mp #(
    parameter int unsigned W  = 8,
    parameter int unsigned D  = 4,
    parameter int unsigned NR = 2
) (
    input  logic            CLK,
    input  logic            Reset_n,
    input  logic            RegWrite0,
    input  logic [D-1:0]    writeReg0,
    input  logic [W-1:0]    writeValue0,
    input  logic            RegWrite1,
    input  logic [D-1:0]    writeReg1,
    input  logic [W-1:0]    writeValue1,
    input  logic [NR*D-1:0] srcIdx,
    output logic [NR*W-1:0] ReadData,
    output logic            Ready
);

    localparam int unsigned Depth = 2 ** D;

    typedef enum logic {
        Clear,
        Run
    } stateT;

    stateT        stateQ, stateD;
    logic [D-1:0] ptrQ, ptrD;
    logic         readyQ, readyD;
    logic [W-1:0] mem [Depth];

    logic         we0Eff;
    logic         we1Eff;

    // Sweep control: one entry per clock, leave Clear after the last entry is written.
    always_comb begin
        stateD = stateQ;
        ptrD   = ptrQ;
        readyD = readyQ;
        unique case (stateQ)
            Clear: begin
                ptrD = ptrQ + 1'b1;
                if (ptrQ == '1) begin
                    stateD = Run;
                    readyD = 1'b1;
                end
            end
            Run: begin
                stateD = Run;
            end
            default: begin
                stateD = Clear;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            stateQ <= Clear;
            ptrQ   <= '0;
            readyQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            ptrQ   <= ptrD;
            readyQ <= readyD;
        end
    end

    // Effective write enables. Port 0 is suppressed only when port 1 actually commits to
    // the same address, so a discarded port-1 write to entry 0 never blocks port 0.
    always_comb begin
        we1Eff = RegWrite1 && (stateQ == Run);
        we0Eff = RegWrite0 && (stateQ == Run);
`ifdef ZERO_REG_EN
        if (writeReg1 == '0) begin
            we1Eff = 1'b0;
        end
        if (writeReg0 == '0) begin
            we0Eff = 1'b0;
        end
`endif
        if (we1Eff && (writeReg1 == writeReg0)) begin
            we0Eff = 1'b0;
        end
    end

    // Storage has no reset; the sweep defines every entry before Ready rises.
    always_ff @(posedge CLK) begin
        if (Reset_n) begin
            if (stateQ == Clear) begin
                mem[ptrQ] <= '0;
            end else begin
                if (we0Eff) begin
                    mem[writeReg0] <= writeValue0;
                end
                if (we1Eff) begin
                    mem[writeReg1] <= writeValue1;
                end
            end
        end
    end

    // Combinational reads with write bypass; forced to zero until the sweep is done.
    always_comb begin
        logic [D-1:0] rdAddr;
        ReadData = '0;
        rdAddr   = '0;
        for (int k = 0; k < NR; k++) begin
            rdAddr = srcIdx[k*D +: D];
            if (!readyQ) begin
                ReadData[k*W +: W] = '0;
`ifdef ZERO_REG_EN
            end else if (rdAddr == '0) begin
                ReadData[k*W +: W] = '0;
`endif
            end else if (RegWrite1 && (writeReg1 == rdAddr)) begin
                ReadData[k*W +: W] = writeValue1;
            end else if (RegWrite0 && (writeReg0 == rdAddr)) begin
                ReadData[k*W +: W] = writeValue0;
            end else begin
                ReadData[k*W +: W] = mem[rdAddr];
            end
        end
    end

    assign Ready = readyQ;

endmodule
